// File: rtl/chronos_pkg.sv
// rtl/chronos_pkg.sv - shared FSM state and owner encodings for the chronos memory arbiter
package chronos_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

endpackage

// File: rtl/chronos_arb_pick.sv
// rtl/chronos_arb_pick.sv - IF/LSU winner selection; starve counter only with CHRONOS_ARB_STARVE_GUARD_EN
module chronos_arb_pick
    import chronos_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
`ifdef CHRONOS_ARB_STARVE_GUARD_EN
    input  logic clk,
    input  logic rst,
    input  logic i_idle,
`endif
    input  logic i_if_req,
    input  logic i_ls_req,
    output logic o_pick_if,
    output logic o_pick_ls
);

`ifdef CHRONOS_ARB_STARVE_GUARD_EN
    logic [3:0] r_starve_cnt;
    logic       w_if_first;

    assign w_if_first = (r_starve_cnt == 4'(STARVE_LIMIT));
    assign o_pick_ls  = i_ls_req && !(w_if_first && i_if_req);
    assign o_pick_if  = i_if_req && !o_pick_ls;

    // Counts LSU wins that left a fetch waiting; only IDLE cycles are decisions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (i_idle) begin
            if (o_pick_if || !i_if_req) begin
                r_starve_cnt <= 4'd0;
            end else if (o_pick_ls) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end
`else
    assign o_pick_ls = i_ls_req;
    assign o_pick_if = i_if_req && !i_ls_req;
`endif

endmodule

// File: rtl/chronos_mem_arbiter.sv
// rtl/chronos_mem_arbiter.sv - single-port memory arbiter between fetch and LSU
// Optional fetch starvation guard: CHRONOS_ARB_STARVE_GUARD_EN.
module chronos_mem_arbiter
    import chronos_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [3:0]        ls_be,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [31:0]       ls_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    arb_state_t        r_state;
    logic              r_owner;
    logic              r_we;
    logic [3:0]        r_be;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic w_idle;
    logic w_pick_if;
    logic w_pick_ls;
    logic w_take;
    logic w_resp;

    // Grants are suppressed while reset is held so every output reads 0.
    assign w_idle = (r_state == ST_IDLE) && !rst;

    chronos_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
`ifdef CHRONOS_ARB_STARVE_GUARD_EN
        .clk      (clk),
        .rst      (rst),
        .i_idle   (w_idle),
`endif
        .i_if_req (if_req),
        .i_ls_req (ls_req),
        .o_pick_if(w_pick_if),
        .o_pick_ls(w_pick_ls)
    );

    assign if_gnt = w_idle && w_pick_if;
    assign ls_gnt = w_idle && w_pick_ls;
    assign w_take = if_gnt || ls_gnt;
    assign w_resp = (r_state == ST_WAIT) && mem_rvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_IF;
            r_we    <= 1'b0;
            r_be    <= 4'h0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_owner <= ls_gnt ? OWN_LS : OWN_IF;
                        r_we    <= ls_gnt && ls_we;
                        r_be    <= ls_gnt ? ls_be : 4'hF;
                        r_addr  <= ls_gnt ? ls_addr : if_addr;
                        r_wdata <= ls_gnt ? ls_wdata : 32'h0;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_gnt) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_req   = (r_state == ST_ISSUE);
    assign mem_we    = r_we;
    assign mem_be    = r_be;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign if_rvalid = w_resp && (r_owner == OWN_IF);
    assign ls_rvalid = w_resp && (r_owner == OWN_LS);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    // Store responses carry no data back to the LSU.
    assign ls_rdata  = (ls_rvalid && !r_we) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_chronos_mem_arbiter.sv
// tb/tb_chronos_mem_arbiter.sv - self-checking bench for chronos_mem_arbiter
module tb_chronos_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    chronos_mem_arbiter #(
        .ADDR_W      (32),
        .STARVE_LIMIT(4)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_be     (ls_be),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_ls;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] rdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        owner;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: every owner rvalid must match the oldest expected response.
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (if_rvalid || ls_rvalid) begin
            check("rsp_onehot", 64'(if_rvalid & ls_rvalid), 64'd0);
            if (sb.size() == 0) begin
                check("rsp_spurious", 64'({if_rvalid, ls_rvalid}), 64'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_owner", 64'(ls_rvalid), 64'(e.owner));
                check("rsp_data", 64'(e.owner ? ls_rdata : if_rdata), 64'(e.data));
            end
        end
    end

    // Called at the negedge of the first ISSUE cycle; ends at the negedge after WAIT.
    task automatic serve(input logic we, input logic [3:0] be, input logic chk_ls,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int dly, input logic [31:0] rdata);
        for (int i = 0; i <= dly; i++) begin
            mem_gnt = (i == dly);
            #1;
            check("issue_mem_req", 64'(mem_req), 64'd1);
            check("issue_mem_addr", 64'(mem_addr), 64'(addr));
            check("issue_mem_we", 64'(mem_we), 64'(we));
            if (chk_ls) begin
                check("issue_mem_be", 64'(mem_be), 64'(be));
                check("issue_mem_wdata", 64'(mem_wdata), 64'(wdata));
            end
            check("busy_no_gnt", 64'({if_gnt, ls_gnt}), 64'd0);
            @(negedge clk);
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        #1;
        check("wait_mem_req", 64'(mem_req), 64'd0);
        check("wait_no_gnt", 64'({if_gnt, ls_gnt}), 64'd0);
        check("wait_rvalid", 64'(if_rvalid | ls_rvalid), 64'd1);
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    localparam int NV = 5;
    vec_t tbl[NV];

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 0, 32'h0000_0013, 32'h0000_0013};
        tbl[1] = '{1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D};
        tbl[2] = '{1'b1, 1'b1, 4'b0011, 32'h0000_0300, 32'hDEAD_BEEF, 3, 32'h1234_5678, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 4'hF, 32'h0000_0104, 32'h0, 2, 32'h00A0_0093, 32'h00A0_0093};
        tbl[4] = '{1'b1, 1'b0, 4'hF, 32'h0000_03FC, 32'h0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

        rst = 1'b1; if_req = 1'b1; if_addr = 32'h0; ls_req = 1'b1; ls_we = 1'b0;
        ls_be = 4'h0; ls_addr = 32'h0; ls_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1;
        check("rst_ctl", 64'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_req, mem_we, mem_be}), 64'd0);
        check("rst_rdata", {if_rdata, ls_rdata}, 64'd0);
        check("rst_mem", {mem_addr, mem_wdata}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0; mem_rvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].is_ls) begin
                ls_req = 1'b1; ls_we = tbl[i].we; ls_be = tbl[i].be;
                ls_addr = tbl[i].addr; ls_wdata = tbl[i].wdata;
            end else begin
                if_req = 1'b1; if_addr = tbl[i].addr;
            end
            #1;
            check("vec_if_gnt", 64'(if_gnt), 64'(!tbl[i].is_ls));
            check("vec_ls_gnt", 64'(ls_gnt), 64'(tbl[i].is_ls));
            sb.push_back('{owner: tbl[i].is_ls, data: tbl[i].exp_rdata});
            @(negedge clk);
            if_req = 1'b0; ls_req = 1'b0;
            serve(tbl[i].we, tbl[i].be, tbl[i].is_ls, tbl[i].addr, tbl[i].wdata,
                  tbl[i].dly, tbl[i].rdata);
        end

        // Contention: LSU first, fetch granted in the first IDLE cycle after.
        if_req = 1'b1; if_addr = 32'h108;
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h200; ls_wdata = 32'h0;
        #1;
        check("both_ls_gnt", 64'(ls_gnt), 64'd1);
        check("both_if_gnt", 64'(if_gnt), 64'd0);
        sb.push_back('{owner: 1'b1, data: 32'hA5A5_0200});
        @(negedge clk);
        ls_req = 1'b0;
        serve(1'b0, 4'hF, 1'b1, 32'h200, 32'h0, 0, 32'hA5A5_0200);
        #1;
        check("after_ls_if_gnt", 64'(if_gnt), 64'd1);
        sb.push_back('{owner: 1'b0, data: 32'h0000_0013});
        @(negedge clk);
        if_req = 1'b0;
        serve(1'b0, 4'hF, 1'b0, 32'h108, 32'h0, 0, 32'h0000_0013);

        // Reset while in WAIT, late response must be dropped.
        if_req = 1'b1; if_addr = 32'h10C;
        #1;
        check("pre_rst_if_gnt", 64'(if_gnt), 64'd1);
        @(negedge clk);
        if_req = 1'b0; mem_gnt = 1'b1;
        #1;
        check("pre_rst_mem_req", 64'(mem_req), 64'd1);
        @(negedge clk);
        mem_gnt = 1'b0;
        rst = 1'b1; if_req = 1'b1; ls_req = 1'b1;
        #1;
        check("midrst_ctl", 64'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_req, mem_we, mem_be}), 64'd0);
        check("midrst_mem", {mem_addr, mem_wdata}, 64'd0);
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0; rst = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
        #1;
        check("late_rsp_rvalid", 64'({if_rvalid, ls_rvalid}), 64'd0);
        check("late_rsp_mem_req", 64'(mem_req), 64'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;

        // Spurious response in IDLE, then prove the FSM is still IDLE.
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        #1;
        check("spur_rvalid", 64'({if_rvalid, ls_rvalid}), 64'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("spur_mem_req", 64'(mem_req), 64'd0);
        if_req = 1'b1; if_addr = 32'h110;
        #1;
        check("spur_then_gnt", 64'(if_gnt), 64'd1);
        sb.push_back('{owner: 1'b0, data: 32'h0000_0033});
        @(negedge clk);
        if_req = 1'b0;
        serve(1'b0, 4'hF, 1'b0, 32'h110, 32'h0, 1, 32'h0000_0033);

`ifdef CHRONOS_ARB_STARVE_GUARD_EN
        if_req = 1'b1; if_addr = 32'h400;
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h500; ls_wdata = 32'h0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("starve_if_gnt", 64'(if_gnt), 64'(k == 4));
            check("starve_ls_gnt", 64'(ls_gnt), 64'(k != 4));
            sb.push_back('{owner: (k != 4), data: 32'h1000 + 32'(k)});
            @(negedge clk);
            if (k == 4) begin
                check("starve_cnt_clear", 64'(u_dut.u_pick.r_starve_cnt), 64'd0);
                if_req = 1'b0; ls_req = 1'b0;
            end
            serve(1'b0, 4'hF, 1'b0, (k == 4) ? 32'h400 : 32'h500, 32'h0, 0, 32'h1000 + 32'(k));
        end
`endif

        @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/chronos_mem_arbiter.md
# chronos_mem_arbiter

Shares the single memory port of the chronosRV32I test harness between the CPU instruction-fetch unit and the load/store unit. Accepts one request at a time, forwards it to memory, and routes the response back to its owner. Sits between `CPU` and the harness memory model, and makes the harness memory single-ported without stalling the core indefinitely.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.
- `STARVE_LIMIT`, 4: consecutive LSU wins tolerated while a fetch is pending (guard build only), range 1..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  **asynchronous, active-high reset.**
- `if_req`  in  1  fetch request; held until `if_gnt`.
- `if_addr`  in  ADDR_W  fetch address, word aligned.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  fetch data valid, one-cycle pulse.
- `if_rdata`  out  32  fetch data.
- `ls_req`  in  1  LSU request; held until `ls_gnt`.
- `ls_we`  in  1  1 = store, 0 = load.
- `ls_be`  in  4  byte enables.
- `ls_addr`  in  ADDR_W  LSU address.
- `ls_wdata`  in  32  store data.
- `ls_gnt`  out  1  LSU request accepted this cycle.
- `ls_rvalid`  out  1  load data or store acknowledge, one-cycle pulse.
- `ls_rdata`  out  32  load data; 0 for stores.
- `mem_req`  out  1  memory request, held until `mem_gnt`.
- `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`  out  1/4/ADDR_W/32  registered request fields.
- `mem_gnt`  in  1  memory accepted the request.
- `mem_rvalid`  in  1  response valid; exactly one per accepted request.
- `mem_rdata`  in  32  response data.

## Operation
- FSM states: IDLE, ISSUE, WAIT. There is one outstanding transaction at most.
- IDLE: if any request is present, the winner's gnt is asserted combinationally. On that edge the request fields and the owner (IF/LS) are latched and the FSM moves to ISSUE. With no request the FSM stays in IDLE.
- Arbitration: LSU has priority over fetch when both request in the same IDLE cycle.
- ISSUE: `mem_req`=1 with the latched fields. When `mem_gnt`=1 the FSM moves to WAIT. The fields must not change while in ISSUE.
- WAIT: `mem_req`=0. When `mem_rvalid`=1 the owner's rvalid is pulsed (combinational pass-through) and rdata is routed to the owner. The non-owner's rvalid stays 0. The FSM returns to IDLE.
- `mem_rdata` for a store is discarded, and `ls_rdata` is forced to 0.
- `mem_rvalid` seen outside WAIT is ignored. No error is flagged.
- A requester dropping req after gnt has no effect on the latched transaction.
- Reset values: FSM=IDLE, owner=IF, starve counter=0, all outputs 0 (`mem_*` fields included).
- Reset mid-transaction: the transaction is abandoned. A later `mem_rvalid` for it is ignored because the FSM is in IDLE.

## Timing
- Best case, with memory granting immediately and responding the next cycle:
  - cycle 0: req and gnt.
  - cycle 1: ISSUE with `mem_gnt`.
  - cycle 2: WAIT with `mem_rvalid`, which is also the owner's rvalid.
- Back-to-back: the next gnt can be asserted in cycle 3 (IDLE). Throughput is therefore one transaction per 3 cycles minimum.
- gnt is never asserted outside IDLE, and only one of `if_gnt`/`ls_gnt` is high in any cycle.

## Configuration
- `CHRONOS_ARB_STARVE_GUARD_EN` defined:
  - A 4-bit counter increments on each LSU win while `if_req`=1.
  - When the counter equals `STARVE_LIMIT`, the next simultaneous IF/LS contention is won by IF.
  - The counter clears on any IF win, or in any IDLE cycle with `if_req`=0.
- Not defined: strict LSU priority, and no counter is instantiated.

## Structure
- Shared package `chronos_pkg`: FSM state enum (IDLE/ISSUE/WAIT) and owner encoding (OWN_IF=0, OWN_LS=1).
- Sub-module `chronos_arb_pick`: combinational winner selection plus the starve counter. The counter is compiled in only under the guard macro.
- The top level holds the FSM, the latched request and the response routing.

## Test plan
- Lone fetch `if_addr`=0x100, memory grants at once and returns 0x00000013 the next cycle -> `if_gnt` in cycle 0, `mem_req` in cycle 1, `if_rvalid`=1 with `if_rdata`=0x00000013 in cycle 2, `ls_rvalid`=0 throughout.
- Simultaneous fetch and load (0x200) -> LSU wins (`ls_gnt`=1, `if_gnt`=0). `mem_addr`=0x200, then the fetch is granted in the first IDLE cycle after the LSU response.
- Store `ls_be`=4'b0011 `ls_wdata`=0xDEADBEEF, `mem_gnt` delayed by 3 cycles -> `mem_req` and the fields stay stable for 4 cycles, then `ls_rvalid`=1 with `ls_rdata`=0.
- Guard build, `STARVE_LIMIT`=4, `ls_req` and `if_req` held high -> LSU wins 4 times, IF wins the 5th grant, and the counter is back at 0.
- `rst` asserted in WAIT, then `mem_rvalid` arrives after reset is released -> all outputs 0 during reset, no rvalid pulse to either requester, FSM in IDLE.
- Spurious `mem_rvalid` in IDLE -> no rvalid to either requester and no state change.
